myriadrf_tx_ctrl: RTL and testbench

Burst/stream sequencer between the TX sample source (FIFO/DMA stream) and the MyriadRF TX interface.
- Gates samples through on start/stop commands.
- Counts samples for fixed-length bursts.
- Substitutes zero samples and counts underruns when the source runs dry mid-run.
- Presents zeros to the interface while idle, so the DAC sees silence rather than stale data.
- Config/status ports are driven by the SoC register block.

---
 rtl/myriadrf_pkg.sv | 16 +
 rtl/myriadrf_tx_ctrl.sv | 113 +++++++++++
 tb/tb_myriadrf_tx_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/myriadrf_pkg.sv
// Shared definitions for the MyriadRF TX control path: FSM state encoding
// and default datapath/counter widths.
package myriadrf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEF_DW     = 24;
  localparam int DEF_CNT_W  = 16;
  localparam int DEF_UCNT_W = 16;

endpackage

// File: rtl/myriadrf_tx_ctrl.sv
// Burst/stream sequencer between the TX sample source and the MyriadRF TX
// interface: start/stop gating, burst counting, zero-fill on underrun.
module myriadrf_tx_ctrl
  import myriadrf_pkg::*;
#(
  parameter int DW     = DEF_DW,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int UCNT_W = DEF_UCNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_enable,
  input  logic              cfg_continuous,
  input  logic [CNT_W-1:0]  cfg_burst_len,
  input  logic              cfg_start,
  input  logic              cfg_stop,
  input  logic [DW-1:0]     s_data_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  output logic [DW-1:0]     m_data_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  sent_cnt_o,
  output logic [UCNT_W-1:0] underrun_cnt_o
);

  state_t            r_state;
  logic [CNT_W-1:0]  r_rem;
  logic              r_cont;
  logic [CNT_W-1:0]  r_sent;
  logic [UCNT_W-1:0] r_urun;
  logic              r_done;

  logic w_run;
  logic w_abort;
  logic w_start;

  assign w_run   = (r_state == ST_RUN);
  assign w_abort = cfg_stop | ~cfg_enable;
  assign w_start = cfg_start & cfg_enable & ~cfg_stop;

  // Zero-latency datapath; everything outside RUN presents silence.
  assign m_valid_o = w_run & s_valid_i;
  assign m_data_o  = (w_run && s_valid_i) ? s_data_i : '0;
  assign s_ready_o = w_run & m_ready_i & s_valid_i & ~w_abort;

  assign busy_o         = (r_state == ST_PRIME) | w_run;
  assign done_o         = r_done;
  assign sent_cnt_o     = r_sent;
  assign underrun_cnt_o = r_urun;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_rem   <= '0;
      r_cont  <= 1'b0;
      r_sent  <= '0;
      r_urun  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_sent <= '0;
            r_urun <= '0;
            r_rem  <= cfg_burst_len;
            r_cont <= cfg_continuous;
            // A zero-length burst completes without touching the source.
            if (!cfg_continuous && cfg_burst_len == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_PRIME;
            end
          end
        end
        ST_PRIME: begin
          if (w_abort) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else if (s_valid_i) begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_abort) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else if (m_ready_i) begin
            if (s_valid_i) begin
              r_sent <= r_sent + 1'b1;
              if (!r_cont) begin
                r_rem <= r_rem - 1'b1;
                if (r_rem == CNT_W'(1)) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
                end
              end
            end else if (r_urun != '1) begin
              r_urun <= r_urun + 1'b1;
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_myriadrf_tx_ctrl.sv
// Self-checking bench for myriadrf_tx_ctrl: directed scenarios followed by a
// randomized phase, all compared against a behavioural model of the sequencer.
module tb_myriadrf_tx_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_enable, cfg_continuous, cfg_start, cfg_stop;
  logic [15:0] cfg_burst_len;
  logic [23:0] s_data_i;
  logic        s_valid_i, m_ready_i;

  logic        s_ready_o, m_valid_o, busy_o, done_o;
  logic [23:0] m_data_o;
  logic [15:0] sent_cnt_o, underrun_cnt_o;

  logic        b_s_ready, b_m_valid, b_busy, b_done;
  logic [23:0] b_m_data;
  logic [15:0] b_sent;
  logic [1:0]  b_urun;

  always #5 clk = ~clk;

  myriadrf_tx_ctrl dut (
    .clk(clk), .rst(rst), .cfg_enable(cfg_enable), .cfg_continuous(cfg_continuous),
    .cfg_burst_len(cfg_burst_len), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .busy_o(busy_o), .done_o(done_o), .sent_cnt_o(sent_cnt_o),
    .underrun_cnt_o(underrun_cnt_o)
  );

  // Narrow underrun counter build, driven in lockstep to exercise saturation.
  myriadrf_tx_ctrl #(.UCNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .cfg_enable(cfg_enable), .cfg_continuous(cfg_continuous),
    .cfg_burst_len(cfg_burst_len), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(b_s_ready),
    .m_data_o(b_m_data), .m_valid_o(b_m_valid), .m_ready_i(m_ready_i),
    .busy_o(b_busy), .done_o(b_done), .sent_cnt_o(b_sent),
    .underrun_cnt_o(b_urun)
  );

  int tests = 0;
  int fails = 0;
  bit rnd_ready = 1'b0;

  // Model: a run is either waiting for first data or streaming; a finish
  // flag marks the single completion-pulse cycle.
  bit md_run, md_wait, md_fin, md_cont;
  int md_rem, md_sent, md_urun, md_urun2;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    md_run = 0; md_wait = 0; md_fin = 0; md_cont = 0;
    md_rem = 0; md_sent = 0; md_urun = 0; md_urun2 = 0;
  endtask

  task automatic check_outs();
    bit act, ab;
    act = md_run && !md_wait;
    ab  = cfg_stop || !cfg_enable;
    chk("m_valid", m_valid_o, act && s_valid_i);
    chk("m_data", m_data_o, (act && s_valid_i) ? s_data_i : 24'd0);
    chk("s_ready", s_ready_o, act && m_ready_i && s_valid_i && !ab);
    chk("busy", busy_o, md_run);
    chk("done", done_o, md_fin);
    chk("sent", sent_cnt_o, md_sent);
    chk("urun", underrun_cnt_o, md_urun);
    chk("urun_sat", b_urun, md_urun2);
  endtask

  task automatic model_step();
    bit ab;
    ab = cfg_stop || !cfg_enable;
    if (md_fin) md_fin = 0;
    else if (!md_run) begin
      if (cfg_start && cfg_enable && !cfg_stop) begin
        md_sent = 0; md_urun = 0; md_urun2 = 0;
        md_rem = cfg_burst_len; md_cont = cfg_continuous;
        if (!md_cont && md_rem == 0) md_fin = 1;
        else begin md_run = 1; md_wait = 1; end
      end
    end else if (ab) begin
      md_run = 0; md_fin = 1;
    end else if (md_wait) begin
      if (s_valid_i) md_wait = 0;
    end else if (m_ready_i) begin
      if (s_valid_i) begin
        md_sent = (md_sent + 1) % 65536;
        if (!md_cont) begin
          md_rem--;
          if (md_rem == 0) begin md_run = 0; md_fin = 1; end
        end
      end else begin
        md_urun  = (md_urun < 65535) ? md_urun + 1 : 65535;
        md_urun2 = (md_urun2 < 3) ? md_urun2 + 1 : 3;
      end
    end
  endtask

  // One clock: check outputs for the current inputs, advance the model,
  // then present the next cycle's default inputs.
  task automatic cyc();
    #1 check_outs();
    model_step();
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
    cfg_stop  = 1'b0;
    m_ready_i = rnd_ready ? 1'($urandom % 2) : ~m_ready_i;
    s_data_i  = 24'($urandom);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    cfg_enable = 1'b1; cfg_continuous = 1'b0; cfg_start = 1'b0; cfg_stop = 1'b0;
    cfg_burst_len = 16'd0; s_data_i = 24'h5a5a5a; s_valid_i = 1'b0; m_ready_i = 1'b0;
    model_reset();
    #1 check_outs();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    cyc();

    // Burst of 4, source always valid
    cfg_burst_len = 16'd4; s_valid_i = 1'b1; cfg_start = 1'b1;
    repeat (14) cyc();
    chk("t1_sent", sent_cnt_o, 16'd4);
    chk("t1_urun", underrun_cnt_o, 16'd0);
    chk("t1_mdata_idle", m_data_o, 24'd0);

    // Underrun for two ready slots after the second sample
    cfg_start = 1'b1;
    repeat (24) begin
      s_valid_i = !(md_run && !md_wait && md_sent == 2 && md_urun < 2);
      cyc();
    end
    chk("t2_sent", sent_cnt_o, 16'd4);
    chk("t2_urun", underrun_cnt_o, 16'd2);

    // Continuous run stopped after 10 samples
    cfg_continuous = 1'b1; s_valid_i = 1'b1; cfg_start = 1'b1;
    cyc();
    for (int i = 0; i < 60 && md_sent < 10; i++) cyc();
    chk("t3_reached10", md_sent, 10);
    cfg_stop = 1'b1;
    cyc();
    chk("t3_done", done_o, 1'b1);
    cyc();
    chk("t3_sent", sent_cnt_o, 16'd10);

    // Edge commands
    cfg_continuous = 1'b0; cfg_burst_len = 16'd0; cfg_start = 1'b1;
    cyc();
    chk("t4_len0_done", done_o, 1'b1);
    cyc();
    cfg_burst_len = 16'd3; cfg_start = 1'b1; cfg_stop = 1'b1;
    cyc();
    chk("t4_startstop_busy", busy_o, 1'b0);
    cfg_enable = 1'b0; cfg_start = 1'b1;
    cyc();
    chk("t4_disabled_busy", busy_o, 1'b0);
    cyc();
    cfg_enable = 1'b1;

    // Prime wait, then reset mid-run
    cfg_burst_len = 16'd8; s_valid_i = 1'b0; cfg_start = 1'b1;
    cyc();
    repeat (6) cyc();
    chk("t5_prime_busy", busy_o, 1'b1);
    chk("t5_prime_urun", underrun_cnt_o, 16'd0);
    s_valid_i = 1'b1;
    repeat (4) cyc();
    chk("t5_running", m_valid_o, 1'b1);
    rst = 1'b1;
    #1;
    model_reset();
    check_outs();
    @(negedge clk);
    rst = 1'b0;
    cyc();

    // Saturation of the narrow underrun counter
    cfg_continuous = 1'b1; s_valid_i = 1'b1; cfg_start = 1'b1;
    cyc();
    cyc();
    s_valid_i = 1'b0;
    repeat (12) cyc();
    chk("t6_sat", b_urun, 2'd3);
    chk("t6_wide", underrun_cnt_o, 16'd6);
    cfg_stop = 1'b1;
    cyc();
    cyc();

    // Randomized commands and traffic
    rnd_ready = 1'b1;
    repeat (400) begin
      cfg_start      = ($urandom % 6) == 0;
      cfg_stop       = ($urandom % 40) == 0;
      cfg_enable     = ($urandom % 50) != 0;
      cfg_continuous = 1'($urandom % 2);
      cfg_burst_len  = 16'($urandom % 7);
      s_valid_i      = ($urandom % 4) != 0;
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
